// File: rtl/win_pkg.sv
// win_pkg: shared defaults, FSM states and tap-offset helper for window_gen
package win_pkg;
  localparam int DEF_IMG_W = 50;
  localparam int DEF_IMG_H = 50;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_ADDR_W = 14;
  localparam int WIN_TAPS = 9;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int tap_lsb(input int dr, input int dc, input int pw);
    return (3 * dr + dc) * pw;
  endfunction
endpackage

// File: rtl/window_gen_if.sv
// window_gen_if: pixel memory read port and window stream; win_last exists only with WIN_LAST_EN
interface window_gen_if import win_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [PIX_W-1:0] mem_rd_data;
  logic win_valid;
  logic win_ready;
  logic [WIN_TAPS*PIX_W-1:0] win_data;
`ifdef WIN_LAST_EN
  logic win_last;
  modport master(output mem_rd_addr, win_valid, win_data, win_last, input mem_rd_data, win_ready);
  modport slave(input mem_rd_addr, win_valid, win_data, win_last, output mem_rd_data, win_ready);
`else
  modport master(output mem_rd_addr, win_valid, win_data, input mem_rd_data, win_ready);
  modport slave(input mem_rd_addr, win_valid, win_data, output mem_rd_data, win_ready);
`endif
endinterface

// File: rtl/line_buffer.sv
// line_buffer: circular row store, read-old-write-new at one index per enabled cycle
module line_buffer #(
  parameter int DEPTH = 50,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [PIX_W-1:0]         din,
  output logic [PIX_W-1:0]         dout
);
  logic [PIX_W-1:0] mem [DEPTH];
  assign dout = mem[idx];
  always_ff @(posedge clk)
    if (en) mem[idx] <= din;
endmodule

// File: rtl/window_gen.sv
// window_gen: raster 3x3 window generator with valid/ready output; WIN_LAST_EN adds win_last
module window_gen import win_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  window_gen_if.master m
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
  state_t state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0] w [WIN_TAPS];
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic advance, qual, last_pix, col_end;
  assign advance = state == RUN && (!m.win_valid || m.win_ready);
  assign qual = row >= RW'(2) && col >= CW'(2);
  assign last_pix = addr == LAST;
  assign col_end = col == CW'(IMG_W - 1);
  assign m.mem_rd_addr = addr;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (start ? RUN : IDLE) :
                state == RUN   ? (advance && last_pix ? DRAIN : RUN) :
                state == DRAIN ? (m.win_valid && m.win_ready ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      addr <= '0;
      col <= '0;
      row <= '0;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      col <= col_end ? '0 : col + CW'(1);
      row <= col_end ? row + RW'(1) : row;
    end
  // taps only move on advance, so they double as the held output window under stall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < WIN_TAPS; i++) w[i] <= '0;
      m.win_valid <= 1'b0;
    end else begin
      if (advance) begin
        for (int i = 0; i < 3; i++) begin
          w[3*i] <= w[3*i+1];
          w[3*i+1] <= w[3*i+2];
        end
        w[2] <= lb0_q;
        w[5] <= lb1_q;
        w[8] <= m.mem_rd_data;
      end
      m.win_valid <= advance ? qual : m.win_valid && !m.win_ready;
    end
`ifdef WIN_LAST_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) m.win_last <= 1'b0;
    else m.win_last <= advance ? last_pix : m.win_last && !m.win_ready;
`endif
  for (genvar i = 0; i < 3; i++) begin : g_r
    for (genvar j = 0; j < 3; j++) begin : g_c
      assign m.win_data[tap_lsb(i, j, PIX_W) +: PIX_W] = w[3*i+j];
    end
  end
  line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk(clk), .en(advance), .idx(col), .din(m.mem_rd_data), .dout(lb1_q)
  );
  line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb0 (
    .clk(clk), .en(advance), .idx(col), .din(lb1_q), .dout(lb0_q)
  );
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: 5x4 and 50x50 frames against a raster-index window model
module tb_window_gen;
  import win_pkg::*;
  localparam int PW = DEF_PIX_W;
  localparam int AW = DEF_ADDR_W;
  localparam int DW = WIN_TAPS * PW;
  logic clk = 0, rst_n = 0, start = 0, ready = 0, sel = 0;
  logic s_busy, s_done, b_busy, b_done;
  logic o_valid, o_busy, o_done;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_addr;
  logic [PW-1:0] img [2**AW];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  window_gen_if #(.PIX_W(PW), .ADDR_W(AW)) sif ();
  window_gen_if #(.PIX_W(PW), .ADDR_W(AW)) bif ();
  assign sif.mem_rd_data = img[sif.mem_rd_addr];
  assign bif.mem_rd_data = img[bif.mem_rd_addr];
  assign sif.win_ready = ready;
  assign bif.win_ready = ready;
  window_gen #(.IMG_W(5), .IMG_H(4)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .busy(s_busy), .done(s_done), .m(sif.master)
  );
  window_gen u_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .busy(b_busy), .done(b_done), .m(bif.master)
  );
  assign o_valid = sel ? bif.win_valid : sif.win_valid;
  assign o_data = sel ? bif.win_data : sif.win_data;
  assign o_addr = sel ? bif.mem_rd_addr : sif.mem_rd_addr;
  assign o_busy = sel ? b_busy : s_busy;
  assign o_done = sel ? b_done : s_done;
`ifdef WIN_LAST_EN
  logic o_last;
  assign o_last = sel ? bif.win_last : sif.win_last;
`endif

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // window n of a w-wide frame is centred on interior pixel (2 + n/(w-2), 2 + n%(w-2))
  function automatic logic [DW-1:0] exp_win(input int w, input int n);
    logic [DW-1:0] e;
    int r, c;
    r = 2 + n / (w - 2);
    c = 2 + n % (w - 2);
    e = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        e[(3*dr+dc)*PW +: PW] = img[(r-2+dr)*w + c-2+dc];
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
`ifdef WIN_LAST_EN
    chk({tag, "_last"}, o_last, 0);
`endif
  endtask

  // mode 0: ready always 1, 1: ready 1,0,0 repeating, 2: random ready
  task automatic run_frame(input int w, input int h, input int mode, input int pulse_at, input int rst_at);
    int total, nwin, cyc, first;
    bit hs, stall, fin;
    logic [DW-1:0] hd;
    logic [AW-1:0] ha;
    total = (w - 2) * (h - 2);
    nwin = 0; cyc = 0; first = -1; hs = 0; stall = 0; fin = 0;
    hd = '0; ha = '0;
    ready = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_addr", o_addr, 0);
    chk("start_busy", o_busy, 1);
    while (!fin && cyc < 20 * w * h) begin
      if (stall) begin
        chk("stall_data", o_data, hd);
        chk("stall_addr", o_addr, ha);
      end
      chk("done", o_done, hs && nwin == total);
      if (hs && nwin == total) begin
        chk("busy_at_done", o_busy, 0);
        fin = 1;
      end else begin
        if (o_valid && first < 0) begin
          first = cyc;
          if (mode == 0) chk("first_valid", cyc, 2 * w + 3);
        end
`ifdef WIN_LAST_EN
        if (o_valid) chk("win_last", o_last, nwin == total - 1);
`endif
        ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
        start = cyc == pulse_at;
        hs = o_valid && ready;
        stall = o_valid && !ready;
        hd = o_data;
        ha = o_addr;
        if (hs) begin
          chk("win", o_data, exp_win(w, nwin));
          nwin++;
        end
        if (hs && nwin == rst_at) begin
          @(posedge clk);
          #1 rst_n = 0;
          #1 chk_zero("mid_rst");
          @(negedge clk);
          start = 0;
          rst_n = 1;
          @(negedge clk);
          chk_zero("after_rst");
          return;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 0;
    chk("frame_done", fin, 1);
    chk("count", nwin, total);
    @(negedge clk);
    chk("done_pulse", o_done, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) img[i] = PW'(i);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    @(negedge clk);
    sel = 0;
    run_frame(5, 4, 0, -1, 0);
    run_frame(5, 4, 1, -1, 0);
    for (int i = 0; i < 2**AW; i++) img[i] = PW'($urandom);
    run_frame(5, 4, 2, 10, 0);
    for (int i = 0; i < 2**AW; i++) img[i] = PW'(i);
    run_frame(5, 4, 0, -1, 3);
    run_frame(5, 4, 0, -1, 0);
    for (int i = 0; i < 2**AW; i++) img[i] = PW'($urandom);
    run_frame(5, 4, 2, -1, 0);
    sel = 1;
    @(negedge clk);
    run_frame(50, 50, 0, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/window_gen.md
# window_gen

Streaming 3x3 window generator sitting between pixel memory and the systolic convolution array. After a start pulse it reads the stored image from memory in raster order, one pixel per cycle, and keeps two line buffers. It emits every fully interior 3x3 neighbourhood as one wide word under a valid/ready handshake. It replaces the free-running address scanner, so the systolic stage can stall the stream without losing pixels.

## Interface
- IMG_W, 50, image width in pixels (>= 3)
- IMG_H, 50, image height in pixels (>= 3)
- PIX_W, 8, pixel width in bits
- ADDR_W, 14, memory address width; IMG_W*IMG_H <= 2^ADDR_W
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to process a frame; honoured only in IDLE
- mem_rd_addr  out  ADDR_W  pixel read address; memory read is combinational (data valid same cycle)
- mem_rd_data  in  PIX_W  pixel at mem_rd_addr
- win_valid  out  1  win_data holds a valid window
- win_ready  in  1  consumer accepts window this cycle
- win_data  out  9*PIX_W  window; slice k = 3*dr+dc, k=0 top-left (r-2,c-2), k=8 newest (r,c)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the last window handshake

## Operation
- States: IDLE -> RUN on start; RUN -> DRAIN when the last pixel (IMG_W*IMG_H-1) is consumed; DRAIN -> DONE when the last window handshakes; DONE -> IDLE unconditionally (done=1 in DONE).
- Pixel consume condition in RUN: `advance = !win_valid || win_ready`. On advance:
  - the pixel is pushed into the 3x3 shift registers and line buffers;
  - mem_rd_addr increments;
  - col/row counters advance: col wraps IMG_W-1 -> 0 and row increments.
- Line buffers are circular and indexed by col:
  - buffer 1 returns the pixel at (r-1,c), then stores (r,c);
  - buffer 0 returns (r-2,c), then stores buffer 1's old output.
- Window emitted only when the consumed pixel has row >= 2 and col >= 2. No padding. Total windows per frame: (IMG_W-2)*(IMG_H-2); 2304 at the defaults.
- Column wrap: at col 0 and col 1 the shift registers still hold the previous row's pixels. No window is produced for those columns.
- win_valid rises on the edge that consumes a qualifying pixel and falls on handshake unless the same edge consumes another qualifying pixel.
- While win_valid && !win_ready:
  - win_data, mem_rd_addr and the counters hold;
  - no memory data is consumed.
- start outside IDLE is ignored.
- Line-buffer contents are not reset; stale data is never emitted because the first two rows only fill.

## Timing
- Reset values: mem_rd_addr=0, win_valid=0, win_data=0, busy=0, done=0, state IDLE, counters 0.
- start sampled high in IDLE at edge E0: state RUN, mem_rd_addr=0 after E0.
- With win_ready held 1, the pixel at address a is consumed at edge E0+1+a.
- First window valid after edge E0+1+(2*IMG_W+2), i.e. E0+103 at the defaults.
- Throughput is 1 window/cycle within a row, with 2 bubble cycles at each row start.
- Final pixel at edge E0+IMG_W*IMG_H; the last window handshakes at the earliest one edge later; done is high in the following cycle.
- Reset asserted mid-frame: all state clears immediately; no done pulse; the next frame requires a new start.

## Configuration
- WIN_LAST_EN defined: adds output win_last (1 bit, reset 0), high together with win_valid for the final window of the frame and held with it under stall.
- Undefined: the port does not exist; frame end is signalled only by done.

## Structure
- Package win_pkg holds:
  - default IMG_W/IMG_H/PIX_W/ADDR_W;
  - WIN_TAPS=9;
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - a function returning the slice offset for tap (dr,dc).
- Sub-module line_buffer: depth IMG_W, width PIX_W, read-old-write-new at one index per enabled cycle. It is instantiated twice.

## Test plan
- IMG_W=5, IMG_H=4, pixel=address, win_ready=1 -> 6 windows.
  - First window k0..k8 = 0,1,2,5,6,7,10,11,12.
  - Last window = 7,8,9,12,13,14,17,18,19.
  - done 1 cycle after the last window.
- Defaults, win_ready=1 -> exactly 2304 handshakes; first win_valid 103 cycles after start; no window for pixel cols 0/1.
- Same 5x4 frame with win_ready toggling 1,0,0 -> identical window sequence; mem_rd_addr and win_data constant during every stall.
- Pulse start during RUN -> ignored; window count unchanged; one done only.
- Drive rst low at window 3 of 6, release, start again -> outputs zero during reset; the new frame produces the full 6-window sequence from 0,1,2,....
- With WIN_LAST_EN on the 5x4 frame -> win_last high only with window 6, including while stalled.
